// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states and widths.
package mdu_pkg;

   localparam int unsigned MduWidth = 32;
   localparam int unsigned MduCntW  = $clog2(MduWidth);

   localparam logic [2:0] OpNop   = 3'd0;
   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;

   function automatic logic op_is_calc(input logic [2:0] op);
      return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == OpMult) || (op == OpDiv);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == OpDiv) || (op == OpDivu);
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-step-per-enable datapath: shift-add multiply or restoring divide on unsigned operands.
module mdu_iter_core #(
   parameter int unsigned WIDTH = mdu_pkg::MduWidth
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               i_load,
   input  logic               i_en,
   input  logic               i_div,
   input  logic [WIDTH-1:0]   i_op_a,
   input  logic [WIDTH-1:0]   i_op_b,
   output logic [2*WIDTH-1:0] o_prod,
   output logic [WIDTH-1:0]   o_quot,
   output logic [WIDTH-1:0]   o_rem
);

   // Upper WIDTH+1 bits: partial product / remainder; lower WIDTH: multiplier / quotient.
   logic [2*WIDTH:0] r_acc;
   logic [WIDTH-1:0] r_opb;
   logic             r_div;

   logic [WIDTH:0]   w_mul_sum;
   logic [2*WIDTH:0] w_mul_next;
   logic [2*WIDTH:0] w_div_shift;
   logic [WIDTH+1:0] w_div_diff;
   logic [2*WIDTH:0] w_div_next;

   always_comb begin
      w_mul_sum   = r_acc[0] ? (r_acc[2*WIDTH:WIDTH] + {1'b0, r_opb}) : r_acc[2*WIDTH:WIDTH];
      w_mul_next  = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
      w_div_shift = {r_acc[2*WIDTH-1:0], 1'b0};
      w_div_diff  = {1'b0, w_div_shift[2*WIDTH:WIDTH]} - {2'b00, r_opb};
      // Borrow out means the trial subtraction failed: keep the shifted remainder.
      if (w_div_diff[WIDTH+1]) begin
         w_div_next = w_div_shift;
      end else begin
         w_div_next = {w_div_diff[WIDTH:0], w_div_shift[WIDTH-1:1], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_acc <= '0;
         r_opb <= '0;
         r_div <= 1'b0;
      end else if (i_load) begin
         r_acc <= {{(WIDTH+1){1'b0}}, i_op_a};
         r_opb <= i_op_b;
         r_div <= i_div;
      end else if (i_en) begin
         r_acc <= r_div ? w_div_next : w_mul_next;
      end
   end

   assign o_prod = r_acc[2*WIDTH-1:0];
   assign o_quot = r_acc[WIDTH-1:0];
   assign o_rem  = r_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: issues MULT/DIV to the iteration core, applies sign fixup, owns HI/LO and stall.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MduWidth
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             i_EX_ctrl_MDUValid,
   input  logic [2:0]       i_EX_ctrl_MDUOp,
   input  logic             i_EX_ctrl_MDURead,
   input  logic [WIDTH-1:0] i_EX_data_RSData,
   input  logic [WIDTH-1:0] i_EX_data_RTData,
   input  logic             i_HZ_ctrl_Cancel,
   output logic             o_HZ_ctrl_Stall,
   output logic [WIDTH-1:0] o_EX_data_HI,
   output logic [WIDTH-1:0] o_EX_data_LO,
   output logic             o_EX_data_Busy,
   output logic             o_EX_data_DivZero
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [CntW-1:0]  r_cnt;
   logic [2:0]       r_op;
   logic             r_sign_a;
   logic             r_sign_b;
   logic             r_b_zero;
   logic [WIDTH-1:0] r_rs_raw;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_div_zero;

   logic             w_idle_ok;
   logic             w_issue;
   logic             w_signed;
   logic             w_sgn_a;
   logic             w_sgn_b;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic [1:0]       w_state_nxt;
   logic             w_last;
   logic             w_dz_nxt;

   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;
   logic               w_neg;
   logic               w_fix_we;
   logic               w_hi_we;
   logic               w_lo_we;
   logic [WIDTH-1:0]   w_hi_nxt;
   logic [WIDTH-1:0]   w_lo_nxt;

   always_comb begin
      w_idle_ok = (r_state == StIdle) && i_EX_ctrl_MDUValid && !i_HZ_ctrl_Cancel;
      w_issue   = w_idle_ok && op_is_calc(i_EX_ctrl_MDUOp);
      w_signed  = op_is_signed(i_EX_ctrl_MDUOp);
      w_sgn_a   = w_signed && i_EX_data_RSData[WIDTH-1];
      w_sgn_b   = w_signed && i_EX_data_RTData[WIDTH-1];
      w_op_a    = w_sgn_a ? -i_EX_data_RSData : i_EX_data_RSData;
      w_op_b    = w_sgn_b ? -i_EX_data_RTData : i_EX_data_RTData;
      w_last    = (r_state == StCalc) && (r_cnt == LastCnt);
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_issue) w_state_nxt = StCalc;
         StCalc:  if (w_last) w_state_nxt = StFix;
         StFix:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
      if (i_HZ_ctrl_Cancel) begin
         w_state_nxt = StIdle;
      end
   end

   // Registered so the pulse lines up with the FIX cycle without depending on live inputs.
   assign w_dz_nxt = w_last && op_is_div(r_op) && r_b_zero && !i_HZ_ctrl_Cancel;

   mdu_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .nrst   (nrst),
      .i_load (w_issue),
      .i_en   (r_state == StCalc),
      .i_div  (op_is_div(i_EX_ctrl_MDUOp)),
      .i_op_a (w_op_a),
      .i_op_b (w_op_b),
      .o_prod (w_prod),
      .o_quot (w_quot),
      .o_rem  (w_rem)
   );

   always_comb begin
      w_neg      = r_sign_a ^ r_sign_b;
      w_prod_fix = w_neg ? -w_prod : w_prod;
      if (!op_is_div(r_op)) begin
         w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
         w_res_lo = w_prod_fix[WIDTH-1:0];
      end else if (r_b_zero) begin
         w_res_hi = r_rs_raw;
         w_res_lo = '1;
      end else begin
         w_res_hi = r_sign_a ? -w_rem : w_rem;
         w_res_lo = w_neg ? -w_quot : w_quot;
      end
   end

   always_comb begin
      w_fix_we = (r_state == StFix) && !i_HZ_ctrl_Cancel;
      w_hi_we  = w_fix_we || (w_idle_ok && (i_EX_ctrl_MDUOp == OpMthi));
      w_lo_we  = w_fix_we || (w_idle_ok && (i_EX_ctrl_MDUOp == OpMtlo));
      w_hi_nxt = w_fix_we ? w_res_hi : i_EX_data_RSData;
      w_lo_nxt = w_fix_we ? w_res_lo : i_EX_data_RSData;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_op       <= OpNop;
         r_sign_a   <= 1'b0;
         r_sign_b   <= 1'b0;
         r_b_zero   <= 1'b0;
         r_rs_raw   <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_div_zero <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_div_zero <= w_dz_nxt;
         if (w_issue) begin
            r_cnt    <= '0;
            r_op     <= i_EX_ctrl_MDUOp;
            r_sign_a <= w_sgn_a;
            r_sign_b <= w_sgn_b;
            r_b_zero <= (i_EX_data_RTData == '0);
            r_rs_raw <= i_EX_data_RSData;
         end else if (r_state == StCalc) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_hi_we) r_hi <= w_hi_nxt;
         if (w_lo_we) r_lo <= w_lo_nxt;
      end
   end

   assign o_EX_data_Busy    = (r_state != StIdle);
   assign o_HZ_ctrl_Stall   = o_EX_data_Busy && (i_EX_ctrl_MDUValid || i_EX_ctrl_MDURead);
   assign o_EX_data_HI      = r_hi;
   assign o_EX_data_LO      = r_lo;
   assign o_EX_data_DivZero = r_div_zero;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table of MULT/DIV results plus hand-written hazard sequences.
module tb_mdu_ctrl;

   logic        clk;
   logic        nrst;
   logic        valid;
   logic [2:0]  op;
   logic        rd;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        cancel;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        dz;

   int n_checks;
   int n_errors;

   mdu_ctrl #(
      .WIDTH (32)
   ) dut (
      .clk                (clk),
      .nrst               (nrst),
      .i_EX_ctrl_MDUValid (valid),
      .i_EX_ctrl_MDUOp    (op),
      .i_EX_ctrl_MDURead  (rd),
      .i_EX_data_RSData   (rs),
      .i_EX_data_RTData   (rt),
      .i_HZ_ctrl_Cancel   (cancel),
      .o_HZ_ctrl_Stall    (stall),
      .o_EX_data_HI       (hi),
      .o_EX_data_LO       (lo),
      .o_EX_data_Busy     (busy),
      .o_EX_data_DivZero  (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      int          dz;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called just after an edge; counts Busy/DivZero/Stall cycles until the first IDLE cycle.
   task automatic wait_idle(output int n_busy, output int n_dz, output int n_stall);
      n_busy  = 0;
      n_dz    = 0;
      n_stall = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!busy) break;
         n_busy++;
         if (dz) n_dz++;
         if (stall) n_stall++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      valid = 1'b1;
      op    = o;
      rs    = a;
      rt    = b;
      step();
      valid = 1'b0;
      op    = 3'd0;
   endtask

   int nb;
   int nd;
   int ns;

   initial begin
      n_checks = 0;
      n_errors = 0;
      nrst   = 1'b0;
      valid  = 1'b0;
      op     = 3'd0;
      rd     = 1'b0;
      rs     = '0;
      rt     = '0;
      cancel = 1'b0;

      vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 0};
      vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0};
      vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0};
      vecs[3] = '{3'd4, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1};
      vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0};
      vecs[5] = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 0};
      vecs[6] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0};
      vecs[7] = '{3'd1, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 0};
      vecs[8] = '{3'd3, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1};
      vecs[9] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0};

      #12;
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      chk("reset_busy", busy, 0);
      chk("reset_stall", stall, 0);
      chk("reset_dz", dz, 0);
      nrst = 1'b1;
      step();

      // MTHI/MTLO: written at the issue edge, no Busy
      issue(3'd5, 32'h12345678, 32'h0);
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_busy", busy, 0);
      issue(3'd6, 32'h9ABCDEF0, 32'h0);
      chk("mtlo_lo", lo, 32'h9ABCDEF0);
      chk("mtlo_hi_kept", hi, 32'h12345678);

      for (int v = 0; v < 10; v++) begin
         issue(vecs[v].op, vecs[v].rs, vecs[v].rt);
         wait_idle(nb, nd, ns);
         chk($sformatf("vec%0d_busy_cycles", v), nb, 33);
         chk($sformatf("vec%0d_hi", v), hi, vecs[v].hi);
         chk($sformatf("vec%0d_lo", v), lo, vecs[v].lo);
         chk($sformatf("vec%0d_divzero", v), nd, vecs[v].dz);
         chk($sformatf("vec%0d_stall_noreq", v), ns, 0);
      end

      // MULTU then MFLO right behind it: stalls WIDTH+1 cycles, then sees the new value
      issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      rd = 1'b1;
      wait_idle(nb, nd, ns);
      chk("mflo_stall_cycles", ns, 33);
      chk("mflo_stall_idle", stall, 0);
      chk("mflo_lo", lo, 32'h00000001);
      chk("mflo_hi", hi, 32'hFFFFFFFE);
      rd = 1'b0;

      // Second MULT held in EX during CALC, issues in the first IDLE cycle
      issue(3'd1, 32'h00000003, 32'h00000004);
      valid = 1'b1;
      op    = 3'd1;
      rs    = 32'h00000005;
      rt    = 32'hFFFFFFFA;
      wait_idle(nb, nd, ns);
      chk("b2b_stall_cycles", ns, 33);
      chk("b2b_first_lo", lo, 32'h0000000C);
      chk("b2b_first_hi", hi, 32'h00000000);
      step();
      valid = 1'b0;
      op    = 3'd0;
      wait_idle(nb, nd, ns);
      chk("b2b_second_busy", nb, 33);
      chk("b2b_second_lo", lo, 32'hFFFFFFE2);
      chk("b2b_second_hi", hi, 32'hFFFFFFFF);

      // Cancel at iteration 10 of a DIV
      issue(3'd5, 32'h0000000A, 32'h0);
      issue(3'd6, 32'h0000000B, 32'h0);
      issue(3'd4, 32'h00000064, 32'h00000000);
      for (int i = 0; i < 10; i++) step();
      cancel = 1'b1;
      rd     = 1'b1;
      #1;
      chk("cancel_stall_before", stall, 1);
      step();
      cancel = 1'b0;
      #1;
      chk("cancel_busy", busy, 0);
      chk("cancel_stall", stall, 0);
      chk("cancel_hi", hi, 32'h0000000A);
      chk("cancel_lo", lo, 32'h0000000B);
      rd = 1'b0;
      nd = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (dz) nd++;
      end
      chk("cancel_no_dz", nd, 0);
      chk("cancel_hi_kept", hi, 32'h0000000A);

      // Cancel in IDLE blocks MTHI and issue
      cancel = 1'b1;
      issue(3'd5, 32'hDEADBEEF, 32'h0);
      chk("idle_cancel_mthi", hi, 32'h0000000A);
      issue(3'd1, 32'h2, 32'h3);
      chk("idle_cancel_issue", busy, 0);
      cancel = 1'b0;

      // Asynchronous reset mid-CALC
      issue(3'd1, 32'h00000003, 32'h00000003);
      for (int i = 0; i < 5; i++) step();
      rd = 1'b1;
      #2;
      nrst = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_stall", stall, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      rd = 1'b0;
      #3;
      nrst = 1'b1;
      step();
      issue(3'd1, 32'h00000007, 32'hFFFFFFFB);
      wait_idle(nb, nd, ns);
      chk("post_rst_busy", nb, 33);
      chk("post_rst_hi", hi, 32'hFFFFFFFF);
      chk("post_rst_lo", lo, 32'hFFFFFFDD);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
